ls_issue_queue: RTL and testbench
=================================

LS_ISSUE_QUEUE -- requirements
Module: ls_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (power of two, 4..32).
REQ-002 SHALL have parameter ROB_W, default 5, ROB id width.
REQ-003 SHALL have parameter NWAKE, default 5, number of wakeup broadcast ports.
REQ-004 SHALL have parameter STORE_ORDER, default 1; 1 = no entry issues past an older unissued store, 0 = fully out-of-order issue.
REQ-005 SHALL have ports clk_in (in, 1, clock) and rst_in (in, 1, reset); one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports rdy_in (in, 1, global enable) and clear_in (in, 1, synchronous flush).
REQ-007 SHALL have ports in_valid (in, 1) and in_ready (out, 1, enqueue handshake).
REQ-008 SHALL have entry fields in_is_store (1), in_rob_id (ROB_W), in_base (32), in_sv (32), in_imm (32).
REQ-009 SHALL have entry dependency fields in_dep1_valid (1), in_dep1 (ROB_W), in_dep2_valid (1), in_dep2 (ROB_W); dep1 = base, dep2 = store value.
REQ-010 SHALL have wakeup ports wk_valid (in, NWAKE), wk_rob_id (in, NWAKE*ROB_W) and wk_value (in, NWAKE*32); port k occupies slice k.
REQ-011 SHALL have ports out_valid (out, 1) and out_ready (in, 1, issue handshake).
REQ-012 SHALL have issue outputs out_is_store (1), out_rob_id (ROB_W), out_addr (32), out_st_value (32) and count (out, clog2(DEPTH)+1, occupied entries).

Function
REQ-013 SHALL assert in_ready iff count < DEPTH, from registered state only; no same-cycle pop bypass.
REQ-014 SHALL accept an entry on an edge where rdy_in & in_valid & in_ready & !clear_in, writing it to the lowest-index free slot.
REQ-015 SHALL mark an operand pending iff its depN_valid is set, using an explicit pending bit; ROB id 0 is a legal tag.
REQ-016 SHALL, when a wakeup port matches a pending operand of a stored entry, capture its value and clear the pending bit at that edge.
REQ-017 SHALL apply the same wakeup to an entry being accepted in that cycle, so no broadcast is lost.
REQ-018 SHALL resolve multiple matching wakeup ports for one operand by letting the lowest port index win.
REQ-019 SHALL treat an entry as eligible when it is valid, both operands are non-pending, and (STORE_ORDER=0 or no older valid store entry exists).
REQ-020 SHALL define age by acceptance order and issue the oldest eligible entry; slot index is irrelevant.
REQ-021 SHALL implement the output register as a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-022 SHALL, in EMPTY with an eligible entry, load that entry into the output register, free its slot, and go to FULL.
REQ-023 SHALL, in FULL with out_ready=1, either reload from the oldest eligible entry (stay FULL) or go to EMPTY if none is eligible.
REQ-024 SHALL, in FULL with out_ready=0, hold all out_* fields stable.
REQ-025 SHALL compute out_addr = base + imm modulo 2^32 at load time and register it.
REQ-026 SHALL give a minimum latency of 2 edges from accept of a fully-ready entry to out_valid=1, and 1 edge from last wakeup to eligibility.
REQ-027 SHALL, on simultaneous accept and issue-load, leave count unchanged; count excludes the output register.
REQ-028 SHALL, when rdy_in=0, change no state and ignore in_valid, out_ready and the wakeup ports.
REQ-029 SHALL, on clear_in=1 (regardless of rdy_in), invalidate all entries, set count=0 and FSM=EMPTY; clear has priority over accept and issue.

Reset
REQ-030 SHALL, on rst_in asserted (asynchronous, any cycle), set all entries invalid, count=0, FSM=EMPTY, out_valid=0, out_* data=0 and in_ready=1.
REQ-031 SHALL leave no partially accepted or issued entry when reset is asserted mid-operation.

Verification
REQ-032 SHALL cover: accept a load with base=0x1000, imm=0xFFFFFFFC, no deps -> out_valid two edges later with out_addr=0x00000FFC.
REQ-033 SHALL cover: fill DEPTH entries, all with dep1=3 -> in_ready=0 and count=DEPTH; wk rob 3 value 8 -> entries issue oldest-first, one per out_ready cycle.
REQ-034 SHALL cover: accept with dep2=0 while wk port 2 broadcasts rob 0 value 0xAB in the same cycle -> entry eligible and out_st_value=0xAB.
REQ-035 SHALL cover STORE_ORDER=1: older store pending on dep + younger ready load -> load not issued until the store issues; with STORE_ORDER=0 the load issues first.
REQ-036 SHALL cover: out_valid=1 with out_ready=0 for 5 cycles -> out_* stable; a clear_in pulse -> out_valid=0 and count=0 next cycle.
REQ-037 SHALL cover: rst_in asserted mid-cycle with 7 entries -> outputs return to reset values before the next edge.

Source files
------------

// File: rtl/ls_issue_queue.sv
// Load/store issue queue: holds memory ops until base/store-value operands wake up, then issues oldest-eligible first.
// Latency: 2 edges from accepting a fully-ready entry to out_valid; 1 edge from the last wakeup to eligibility.
// Backpressure: in_ready drops when all DEPTH slots are occupied; out_* hold while out_valid=1 and out_ready=0.
module ls_issue_queue #(
    parameter int DEPTH       = 16,
    parameter int ROB_W       = 5,
    parameter int NWAKE       = 5,
    parameter int STORE_ORDER = 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_is_store,
    input  logic [ROB_W-1:0]        in_rob_id,
    input  logic [31:0]             in_base,
    input  logic [31:0]             in_sv,
    input  logic [31:0]             in_imm,
    input  logic                    in_dep1_valid,
    input  logic [ROB_W-1:0]        in_dep1,
    input  logic                    in_dep2_valid,
    input  logic [ROB_W-1:0]        in_dep2,
    input  logic [NWAKE-1:0]        wk_valid,
    input  logic [NWAKE*ROB_W-1:0]  wk_rob_id,
    input  logic [NWAKE*32-1:0]     wk_value,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_is_store,
    output logic [ROB_W-1:0]        out_rob_id,
    output logic [31:0]             out_addr,
    output logic [31:0]             out_st_value,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    // One queue slot; p1/p2 are explicit pending bits so tag 0 is an ordinary ROB id.
    typedef struct packed {
        logic             is_store;
        logic [ROB_W-1:0] rob_id;
        logic [31:0]      base;
        logic [31:0]      sv;
        logic [31:0]      imm;
        logic             p1;
        logic [ROB_W-1:0] t1;
        logic             p2;
        logic [ROB_W-1:0] t2;
    } entry_t;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    entry_t           ent_q   [DEPTH];
    entry_t           ent_wk  [DEPTH];
    logic [DEPTH-1:0] vld_q;
    // older_q[j][i] set means slot j was accepted before slot i.
    logic [DEPTH-1:0] older_q [DEPTH];
    state_t           state_q;

    entry_t           in_ent;
    entry_t           in_wk;
    logic [DEPTH-1:0] blocked;
    logic [DEPTH-1:0] elig;
    logic [DEPTH-1:0] has_older;
    logic             any_elig;
    logic [IW-1:0]    sel_idx;
    logic [IW-1:0]    free_idx;
    logic             accept;
    logic             issue_load;

    // Capture broadcast values into pending operands; the descending scan lets the lowest port win.
    function automatic entry_t apply_wake(input entry_t e,
                                          input logic [NWAKE-1:0] v,
                                          input logic [NWAKE*ROB_W-1:0] ids,
                                          input logic [NWAKE*32-1:0] vals);
        entry_t r;
        r = e;
        for (int k = NWAKE - 1; k >= 0; k--) begin
            if (v[k] && e.p1 && (ids[k*ROB_W +: ROB_W] == e.t1)) begin
                r.p1   = 1'b0;
                r.base = vals[k*32 +: 32];
            end
            if (v[k] && e.p2 && (ids[k*ROB_W +: ROB_W] == e.t2)) begin
                r.p2 = 1'b0;
                r.sv = vals[k*32 +: 32];
            end
        end
        return r;
    endfunction

    assign in_ready   = (count < CW'(DEPTH));
    assign accept     = rdy_in & in_valid & in_ready & ~clear_in;
    assign issue_load = rdy_in & ~clear_in & (~out_valid | out_ready) & any_elig;

    // Build the incoming entry and apply this cycle's wakeups to it and to every stored slot.
    always_comb begin
        in_ent          = '0;
        in_ent.is_store = in_is_store;
        in_ent.rob_id   = in_rob_id;
        in_ent.base     = in_base;
        in_ent.sv       = in_sv;
        in_ent.imm      = in_imm;
        in_ent.p1       = in_dep1_valid;
        in_ent.t1       = in_dep1;
        in_ent.p2       = in_dep2_valid;
        in_ent.t2       = in_dep2;
        in_wk           = apply_wake(in_ent, wk_valid, wk_rob_id, wk_value);
        for (int i = 0; i < DEPTH; i++) begin
            ent_wk[i] = apply_wake(ent_q[i], wk_valid, wk_rob_id, wk_value);
        end
    end

    // Eligibility from registered state: operands ready and, when ordering stores, no older store waiting.
    always_comb begin
        blocked = '0;
        elig    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (STORE_ORDER != 0) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (vld_q[j] && ent_q[j].is_store && older_q[j][i]) begin
                        blocked[i] = 1'b1;
                    end
                end
            end
            elig[i] = vld_q[i] && !ent_q[i].p1 && !ent_q[i].p2 && !blocked[i];
        end
    end

    // Pick the eligible slot with no older eligible slot; age order is total, so exactly one wins.
    always_comb begin
        has_older = '0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (elig[j] && older_q[j][i]) begin
                    has_older[i] = 1'b1;
                end
            end
            if (elig[i] && !has_older[i]) begin
                sel_idx = IW'(i);
            end
        end
        any_elig = |elig;
    end

    // Lowest-index free slot for the next accept.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                free_idx = IW'(i);
            end
        end
    end

    // Slot storage, age matrix and occupancy; clear outranks accept and issue.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_q <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else if (clear_in) begin
            vld_q <= '0;
            count <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_wk[i];
            end
            if (issue_load) begin
                vld_q[sel_idx] <= 1'b0;
            end
            if (accept) begin
                vld_q[free_idx] <= 1'b1;
                ent_q[free_idx] <= in_wk;
                for (int j = 0; j < DEPTH; j++) begin
                    older_q[j][free_idx] <= (j != int'(free_idx));
                    older_q[free_idx][j] <= 1'b0;
                end
            end
            count <= count + CW'(accept) - CW'(issue_load);
        end
    end

    // Output register FSM: EMPTY/FULL, reloading from the oldest eligible slot whenever it may advance.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= S_EMPTY;
            out_valid    <= 1'b0;
            out_is_store <= 1'b0;
            out_rob_id   <= '0;
            out_addr     <= '0;
            out_st_value <= '0;
        end else if (clear_in) begin
            state_q   <= S_EMPTY;
            out_valid <= 1'b0;
        end else if (rdy_in && (state_q == S_EMPTY || out_ready)) begin
            if (any_elig) begin
                state_q      <= S_FULL;
                out_valid    <= 1'b1;
                out_is_store <= ent_q[sel_idx].is_store;
                out_rob_id   <= ent_q[sel_idx].rob_id;
                out_addr     <= ent_q[sel_idx].base + ent_q[sel_idx].imm;
                out_st_value <= ent_q[sel_idx].sv;
            end else begin
                state_q   <= S_EMPTY;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ls_issue_queue.sv
// Directed scoreboard bench for ls_issue_queue (store-ordered instance plus a fully out-of-order twin).
// Latency: expectations assume 2 edges accept-to-issue and 1 edge wakeup-to-eligible.
// Backpressure: out_ready is driven explicitly; stalls and full-queue rejection are exercised.
module tb_ls_issue_queue;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         rdy_in;
    logic         clear_in;
    logic         in_valid;
    logic         in_is_store;
    logic [4:0]   in_rob_id;
    logic [31:0]  in_base;
    logic [31:0]  in_sv;
    logic [31:0]  in_imm;
    logic         in_dep1_valid;
    logic [4:0]   in_dep1;
    logic         in_dep2_valid;
    logic [4:0]   in_dep2;
    logic [4:0]   wk_valid;
    logic [24:0]  wk_rob_id;
    logic [159:0] wk_value;
    logic         out_ready;

    logic         in_ready,     in_ready0;
    logic         out_valid,    out_valid0;
    logic         out_is_store, out_is_store0;
    logic [4:0]   out_rob_id,   out_rob_id0;
    logic [31:0]  out_addr,     out_addr0;
    logic [31:0]  out_st_value, out_st_value0;
    logic [4:0]   count,        count0;

    typedef struct {
        logic [4:0]  rob;
        logic [31:0] addr;
        logic [31:0] sv;
        logic        st;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk_in = ~clk_in;

    ls_issue_queue #(.DEPTH(16), .ROB_W(5), .NWAKE(5), .STORE_ORDER(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_rob_id(in_rob_id), .in_base(in_base), .in_sv(in_sv), .in_imm(in_imm),
        .in_dep1_valid(in_dep1_valid), .in_dep1(in_dep1),
        .in_dep2_valid(in_dep2_valid), .in_dep2(in_dep2),
        .wk_valid(wk_valid), .wk_rob_id(wk_rob_id), .wk_value(wk_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_is_store(out_is_store),
        .out_rob_id(out_rob_id), .out_addr(out_addr), .out_st_value(out_st_value),
        .count(count)
    );

    ls_issue_queue #(.DEPTH(16), .ROB_W(5), .NWAKE(5), .STORE_ORDER(0)) dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .in_valid(in_valid), .in_ready(in_ready0), .in_is_store(in_is_store),
        .in_rob_id(in_rob_id), .in_base(in_base), .in_sv(in_sv), .in_imm(in_imm),
        .in_dep1_valid(in_dep1_valid), .in_dep1(in_dep1),
        .in_dep2_valid(in_dep2_valid), .in_dep2(in_dep2),
        .wk_valid(wk_valid), .wk_rob_id(wk_rob_id), .wk_value(wk_value),
        .out_valid(out_valid0), .out_ready(out_ready), .out_is_store(out_is_store0),
        .out_rob_id(out_rob_id0), .out_addr(out_addr0), .out_st_value(out_st_value0),
        .count(count0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [4:0] rob, input logic [31:0] addr,
                        input logic [31:0] sv, input logic st);
        exp_t e;
        e.rob  = rob;
        e.addr = addr;
        e.sv   = sv;
        e.st   = st;
        sb.push_back(e);
    endtask

    task automatic set_wake(input int port, input logic [4:0] rob, input logic [31:0] val);
        wk_valid[port]           = 1'b1;
        wk_rob_id[port*5 +: 5]   = rob;
        wk_value[port*32 +: 32]  = val;
    endtask

    task automatic clr_wake();
        wk_valid  = '0;
        wk_rob_id = '0;
        wk_value  = '0;
    endtask

    task automatic enq(input logic st, input logic [4:0] rob, input logic [31:0] base,
                       input logic [31:0] sv, input logic [31:0] imm,
                       input logic d1v, input logic [4:0] d1,
                       input logic d2v, input logic [4:0] d2);
        in_valid      = 1'b1;
        in_is_store   = st;
        in_rob_id     = rob;
        in_base       = base;
        in_sv         = sv;
        in_imm        = imm;
        in_dep1_valid = d1v;
        in_dep1       = d1;
        in_dep2_valid = d2v;
        in_dep2       = d2;
        tick();
        in_valid      = 1'b0;
        in_dep1_valid = 1'b0;
        in_dep2_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_vld"}, 64'(out_valid), 64'(1));
    endtask

    task automatic sb_compare(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_rob"}, 64'(out_rob_id), 64'(e.rob));
            check({tag, "_addr"}, 64'(out_addr), 64'(e.addr));
            check({tag, "_st"}, 64'(out_is_store), 64'(e.st));
            if (e.st) check({tag, "_sv"}, 64'(out_st_value), 64'(e.sv));
        end
    endtask

    task automatic pop_check(input string tag);
        wait_valid(tag);
        sb_compare(tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; in_valid = 1'b0;
        in_is_store = 1'b0; in_rob_id = '0; in_base = '0; in_sv = '0; in_imm = '0;
        in_dep1_valid = 1'b0; in_dep1 = '0; in_dep2_valid = 1'b0; in_dep2 = '0;
        out_ready = 1'b0;
        clr_wake();
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_addr", 64'(out_addr), 64'(0));
        tick();
        tick();
        rst_in = 1'b0;
        tick();

        // Wrapping address, two-edge latency.
        enq(1'b0, 5'd1, 32'h1000, 32'h0, 32'hFFFF_FFFC, 1'b0, 5'd0, 1'b0, 5'd0);
        push(5'd1, 32'h0000_0FFC, 32'h0, 1'b0);
        check("lat_edge1_vld", 64'(out_valid), 64'(0));
        check("lat_edge1_cnt", 64'(count), 64'(1));
        tick();
        check("lat_edge2_vld", 64'(out_valid), 64'(1));
        check("lat_edge2_cnt", 64'(count), 64'(0));
        pop_check("wrap");

        // Fill all slots waiting on rob 3, then one shared wakeup.
        for (int i = 0; i < 16; i++) begin
            enq(1'b0, 5'(16 + i), 32'h0, 32'(i), 32'(4 * i), 1'b1, 5'd3, 1'b0, 5'd0);
            push(5'(16 + i), 32'(8 + 4 * i), 32'(i), 1'b0);
        end
        check("full_in_ready", 64'(in_ready), 64'(0));
        check("full_count", 64'(count), 64'(16));
        check("full_no_issue", 64'(out_valid), 64'(0));
        enq(1'b0, 5'd30, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        check("full_reject_cnt", 64'(count), 64'(16));
        set_wake(0, 5'd3, 32'd8);
        tick();
        clr_wake();
        out_ready = 1'b1;
        wait_valid("burst_first");
        for (int i = 0; i < 16; i++) begin
            check("burst_vld", 64'(out_valid), 64'(1));
            sb_compare("burst");
            tick();
        end
        out_ready = 1'b0;
        check("burst_drained_vld", 64'(out_valid), 64'(0));
        check("burst_drained_cnt", 64'(count), 64'(0));

        // Age beats slot index: C lands in a lower slot than B but is younger.
        enq(1'b0, 5'd1, 32'h40, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        push(5'd1, 32'h40, 32'h0, 1'b0);
        enq(1'b0, 5'd2, 32'h0, 32'h0, 32'h4, 1'b1, 5'd7, 1'b0, 5'd0);
        push(5'd2, 32'h74, 32'h0, 1'b0);
        enq(1'b0, 5'd3, 32'h0, 32'h0, 32'h8, 1'b1, 5'd7, 1'b0, 5'd0);
        push(5'd3, 32'h78, 32'h0, 1'b0);
        set_wake(3, 5'd7, 32'h70);
        tick();
        clr_wake();
        pop_check("age_a");
        pop_check("age_b");
        pop_check("age_c");

        // Same-cycle wakeup of an accepting entry on tag 0; port 2 beats port 3.
        set_wake(0, 5'd1, 32'h55);
        set_wake(2, 5'd0, 32'hAB);
        set_wake(3, 5'd0, 32'hCD);
        enq(1'b1, 5'd5, 32'h200, 32'h0, 32'h4, 1'b0, 5'd0, 1'b1, 5'd0);
        clr_wake();
        push(5'd5, 32'h204, 32'hAB, 1'b1);
        pop_check("samecyc");

        // Store ordering: younger ready load waits behind pending store unless ordering is off.
        enq(1'b1, 5'd20, 32'h0, 32'h5A5A, 32'h10, 1'b1, 5'd12, 1'b0, 5'd0);
        push(5'd20, 32'h110, 32'h5A5A, 1'b1);
        enq(1'b0, 5'd21, 32'h300, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        push(5'd21, 32'h300, 32'h0, 1'b0);
        tick();
        tick();
        tick();
        check("so1_blocked", 64'(out_valid), 64'(0));
        check("so0_vld", 64'(out_valid0), 64'(1));
        check("so0_rob", 64'(out_rob_id0), 64'(21));
        check("so0_addr", 64'(out_addr0), 64'(32'h300));
        set_wake(1, 5'd12, 32'h100);
        set_wake(4, 5'd12, 32'h999);
        tick();
        clr_wake();
        pop_check("so_store");
        check("so0_second_rob", 64'(out_rob_id0), 64'(20));
        check("so0_second_addr", 64'(out_addr0), 64'(32'h110));
        pop_check("so_load");
        check("so0_drained", 64'(out_valid0), 64'(0));

        // Simultaneous accept and load keeps count; stall holds outputs; clear flushes.
        enq(1'b0, 5'd24, 32'h500, 32'h0, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0);
        push(5'd24, 32'h501, 32'h0, 1'b0);
        check("acc_cnt", 64'(count), 64'(1));
        enq(1'b0, 5'd25, 32'h600, 32'h0, 32'h2, 1'b0, 5'd0, 1'b0, 5'd0);
        push(5'd25, 32'h602, 32'h0, 1'b0);
        check("acc_load_cnt", 64'(count), 64'(1));
        check("acc_load_vld", 64'(out_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_vld", 64'(out_valid), 64'(1));
            check("hold_rob", 64'(out_rob_id), 64'(sb[0].rob));
            check("hold_addr", 64'(out_addr), 64'(sb[0].addr));
        end
        rdy_in = 1'b0; clear_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        rdy_in = 1'b1; clear_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("clear_vld", 64'(out_valid), 64'(0));
        check("clear_cnt", 64'(count), 64'(0));
        sb.delete();

        // rdy_in low freezes everything, including wakeups.
        enq(1'b0, 5'd27, 32'h0, 32'h0, 32'h0, 1'b1, 5'd13, 1'b0, 5'd0);
        check("frz_pre_cnt", 64'(count), 64'(1));
        rdy_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        set_wake(0, 5'd13, 32'h77);
        tick();
        rdy_in = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        clr_wake();
        check("frz_cnt", 64'(count), 64'(1));
        tick();
        tick();
        check("frz_no_wake", 64'(out_valid), 64'(0));
        set_wake(0, 5'd13, 32'h80);
        tick();
        clr_wake();
        push(5'd27, 32'h80, 32'h0, 1'b0);
        pop_check("frz_after");

        // Asynchronous reset in the middle of a cycle with 7 queued entries.
        enq(1'b0, 5'd26, 32'h700, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < 7; i++) begin
            enq(1'b0, 5'(8 + i), 32'h0, 32'h0, 32'h0, 1'b1, 5'd15, 1'b0, 5'd0);
        end
        check("pre_rst_cnt", 64'(count), 64'(7));
        check("pre_rst_vld", 64'(out_valid), 64'(1));
        #3;
        rst_in = 1'b1;
        #1;
        check("mid_rst_vld", 64'(out_valid), 64'(0));
        check("mid_rst_cnt", 64'(count), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        check("mid_rst_addr", 64'(out_addr), 64'(0));
        check("mid_rst_rob", 64'(out_rob_id), 64'(0));
        check("mid_rst_sv", 64'(out_st_value), 64'(0));
        tick();
        rst_in = 1'b0;
        sb.delete();
        tick();
        enq(1'b0, 5'd9, 32'h10, 32'h0, 32'h20, 1'b0, 5'd0, 1'b0, 5'd0);
        push(5'd9, 32'h30, 32'h0, 1'b0);
        pop_check("post_rst");
        check("post_rst_cnt", 64'(count), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
